// File: rtl/x2050_pkg.sv
// x2050_pkg -- shared definitions for the x2050 storage arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE / OWN_A / OWN_B)
//   TMO_DEFAULT : default ack-timeout in cycles
//   OUT_W       : width of the outstanding-transfer counter
package x2050_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam int unsigned TMO_DEFAULT = 255;
    localparam int unsigned OUT_W       = 4;

endpackage

// File: rtl/x2050_ms_arb_pick.sv
// x2050_ms_arb_pick -- combinational winner select for the storage arbiter.
//   cyc_a, cyc_b : request (cycle) lines of master A and master B
//   last_owner   : master granted last (0 = A, 1 = B)
//   winner       : selected master (0 = A, 1 = B); meaningless when neither requests
module x2050_ms_arb_pick (
    input  logic cyc_a,
    input  logic cyc_b,
    input  logic last_owner,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (cyc_a && cyc_b) begin
            winner = !last_owner;
        end else if (cyc_b) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/x2050_ms_arb.sv
// x2050_ms_arb -- two-master Wishbone pipelined arbiter in front of main storage.
//   Master A (CPU storage control) : i_a_cyc/stb/we/addr/data/sel in, o_a_stall/ack/err/data out
//   Master B (I/O channel)         : i_b_* in, o_b_* out (same set as A)
//   Slave side (main storage)      : o_cyc/stb/we/addr/data/sel out, i_stall/ack/err/data in
//   o_grant   : one-hot owner, bit0 = A, bit1 = B
//   o_timeout : one-cycle pulse when an outstanding transfer goes unacked for TMO cycles
// Configuration macro X2050_MS_ARB_RR_EN: when defined, simultaneous requests
// alternate using a last-owner flop (resets to A, so B wins first); otherwise
// fixed priority B > A.
module x2050_ms_arb
    import x2050_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 30,
    parameter int TMO = int'(TMO_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,

    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,

    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_stall,
    input  logic            i_ack,
    input  logic            i_err,
    input  logic [DW-1:0]   i_data,

    output logic [1:0]      o_grant,
    output logic            o_timeout
);

    localparam logic [7:0]       TMO_LAST = 8'(TMO - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = '1;

    arb_state_t       state, state_nx;
    logic [OUT_W-1:0] out_cnt;
    logic [7:0]       tmo_cnt;
    logic             own_a, own_b, own;
    logic             src_cyc, src_stb, src_we;
    logic [AW-1:0]    src_addr;
    logic [DW-1:0]    src_data;
    logic [DW/8-1:0]  src_sel;
    logic             full, waiting, tmo_fire, leave, accept, done;
    logic             owner_stall, owner_err;
    logic             winner, last_owner;

    // Ownership is masked by rst so a reset cycle never forwards a late ack.
    assign own_a = (state == OWN_A) && !rst;
    assign own_b = (state == OWN_B) && !rst;
    assign own   = own_a || own_b;

    always_comb begin
        src_cyc  = own_b ? i_b_cyc  : i_a_cyc;
        src_stb  = own_b ? i_b_stb  : i_a_stb;
        src_we   = own_b ? i_b_we   : i_a_we;
        src_addr = own_b ? i_b_addr : i_a_addr;
        src_data = own_b ? i_b_data : i_a_data;
        src_sel  = own_b ? i_b_sel  : i_a_sel;
    end

    assign full    = (out_cnt == OUT_MAX);
    assign waiting = own && (out_cnt != '0) && !i_ack;
    // Fires in the cycle whose wait would bring the count to TMO, so the
    // error lands TMO cycles after the unanswered strobe was accepted.
    assign tmo_fire = waiting && (tmo_cnt == TMO_LAST);
    assign leave    = !src_cyc || tmo_fire;

    x2050_ms_arb_pick u_pick (
        .cyc_a      (i_a_cyc),
        .cyc_b      (i_b_cyc),
        .last_owner (last_owner),
        .winner     (winner)
    );

`ifdef X2050_MS_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && (i_a_cyc || i_b_cyc)) begin
            last_owner <= winner;
        end
    end
`else
    assign last_owner = 1'b0;
`endif

    always_comb begin
        o_cyc       = own && src_cyc && !tmo_fire;
        // A full counter holds the strobe back so the slave never sees a 16th transfer.
        o_stb       = o_cyc && src_stb && !full;
        o_we        = own && src_we;
        o_addr      = own ? src_addr : '0;
        o_data      = own ? src_data : '0;
        o_sel       = own ? src_sel  : '0;
        owner_stall = i_stall || full || tmo_fire;
        owner_err   = i_err || tmo_fire;
        o_a_stall   = own_a ? owner_stall : 1'b1;
        o_a_ack     = own_a && i_ack;
        o_a_err     = own_a && owner_err;
        o_b_stall   = own_b ? owner_stall : 1'b1;
        o_b_ack     = own_b && i_ack;
        o_b_err     = own_b && owner_err;
        o_grant     = {own_b, own_a};
        o_timeout   = tmo_fire;
    end

    assign o_a_data = i_data;
    assign o_b_data = i_data;

    assign accept = o_stb && !i_stall;
    assign done   = own && (i_ack || i_err);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:         if (i_a_cyc || i_b_cyc) state_nx = winner ? OWN_B : OWN_A;
            OWN_A, OWN_B: if (leave) state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            if (!own || leave) begin
                out_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                unique case ({accept, done})
                    2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                    2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - OUT_W'(1);
                    default: out_cnt <= out_cnt;
                endcase
                tmo_cnt <= waiting ? tmo_cnt + 8'd1 : '0;
            end
        end
    end

endmodule

// File: doc/x2050_ms_arb.md
X2050_MS_ARB -- requirements
Module: x2050_ms_arb

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 30, word address width.
REQ-003 SHALL have parameter TMO, default 255, cycles without ack before a timeout is declared; legal range 1..255.
REQ-004 SHALL have port clk, in, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-006 SHALL have ports i_a_cyc/i_a_stb/i_a_we, in, 1 each, Wishbone master A (CPU storage control) cycle, strobe and write.
REQ-007 SHALL have ports i_a_addr/i_a_data/i_a_sel, in, AW/DW/DW/8, master A address, write data and byte selects.
REQ-008 SHALL have ports o_a_stall/o_a_ack/o_a_err, out, 1 each, and o_a_data, out, DW, master A responses.
REQ-009 SHALL have ports i_b_* and o_b_*, same set and widths as A, for master B (I/O channel).
REQ-010 SHALL have ports o_cyc/o_stb/o_we, out, 1; o_addr, out, AW; o_data, out, DW; o_sel, out, DW/8; these form the slave-side (main storage) request.
REQ-011 SHALL have ports i_stall/i_ack/i_err, in, 1, and i_data, in, DW, slave-side responses.
REQ-012 SHALL have port o_grant, out, 2, one-hot current owner: bit0 = A, bit1 = B.
REQ-013 SHALL have port o_timeout, out, 1, one-cycle pulse when a timeout fires.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, OWN_A and OWN_B.
REQ-015 In IDLE, with only one requester's cyc asserted, SHALL enter that requester's OWN state on the next edge.
REQ-016 In IDLE, with both cyc asserted, SHALL grant B under fixed priority.
REQ-017 Grant latency SHALL be exactly one cycle: cyc rises in cycle N, o_cyc and o_grant are asserted in cycle N+1.
REQ-018 In OWN_x, the owner's cyc/stb/we/addr/data/sel SHALL pass combinationally to the slave, and i_stall/i_ack/i_err SHALL pass combinationally to the owner.
REQ-019 The non-owner, and both masters in IDLE, SHALL see stall=1, ack=0, err=0.
REQ-020 o_a_data and o_b_data SHALL both equal i_data at all times.
REQ-021 SHALL keep a 4-bit outstanding counter: +1 on o_stb&!i_stall, -1 on i_ack|i_err, net 0 when both occur in the same cycle.
REQ-022 The outstanding counter SHALL never exceed 15; the arbiter SHALL force stall to the owner when the count is 15.
REQ-023 When the owner drops cyc, the FSM SHALL go to IDLE on the next edge and clear the outstanding counter (Wishbone abort).
REQ-024 o_cyc SHALL follow the owner's cyc, so it drops in the same cycle the owner drops cyc.
REQ-025 If the owner drops cyc in the same cycle the other master raises it, SHALL pass through exactly one IDLE cycle before granting the other master.
REQ-026 SHALL keep an 8-bit timeout counter: increment while outstanding>0 and !i_ack; clear on i_ack, on outstanding==0, or on leaving OWN_x.
REQ-027 When the timeout counter reaches TMO, SHALL in that cycle assert the owner's err for 1 cycle, pulse o_timeout, force o_cyc=0, clear both counters, and go to IDLE.
REQ-028 A slave i_err SHALL be forwarded to the owner without changing FSM state.

Reset
REQ-029 On rst, including mid-transfer, SHALL set state IDLE and clear both counters; the previous owner SHALL receive no ack after reset.
REQ-030 On rst, SHALL drive o_cyc=0, o_stb=0, o_grant=0, o_timeout=0, o_a_ack=o_b_ack=0, o_a_err=o_b_err=0 and o_a_stall=o_b_stall=1.

Configuration
REQ-031 Macro X2050_MS_ARB_RR_EN SHALL be the only configuration switch.
REQ-032 With X2050_MS_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the master not granted last, using a last-owner flop that resets to A so B wins first.
REQ-033 Without X2050_MS_ARB_RR_EN, SHALL use fixed priority B>A and contain no last-owner flop.

Structure
REQ-034 Shared package x2050_pkg SHALL hold the FSM state enum (IDLE/OWN_A/OWN_B), the TMO default and the outstanding-counter width.
REQ-035 SHALL instantiate exactly one sub-module, x2050_ms_arb_pick, a combinational winner select (inputs: cyc_a, cyc_b, last_owner; output: winner); all sequential logic stays in the top.

Verification
REQ-036 A single read: A cyc/stb at addr 0x40 in cycle 0 -> o_cyc in cycle 1; memory ack returns 0x12345678 on o_a_data; o_grant=01.
REQ-037 Simultaneous A and B requests in IDLE -> B owns first; repeat with X2050_MS_ARB_RR_EN defined -> B then A.
REQ-038 A pipelines 3 strobes and is acked after 2 -> stall stays 0, outstanding counter shows 3 then 0, release after cyc drop.
REQ-039 Slave never acks with TMO=8 -> o_a_err and o_timeout pulse 8 cycles after the strobe; state returns to IDLE.
REQ-040 B drops cyc in the same cycle A raises it -> one IDLE cycle, then o_grant=01.
REQ-041 rst asserted with 2 transfers outstanding -> next cycle o_cyc=0, o_grant=00, and no ack reaches either master.
